// File: rtl/vpu_pkg.sv
// Shared definitions for the lane-masked vector unit: command encoding,
// field positions and the controller state type.
package vpu_pkg;

    localparam logic [7:0] CLASS_VEC   = 8'h02;

    localparam logic [7:0] OP_VADD     = 8'h01;
    localparam logic [7:0] OP_VSUB     = 8'h02;
    localparam logic [7:0] OP_VMUL     = 8'h03;
    localparam logic [7:0] OP_VMAX     = 8'h04;
    localparam logic [7:0] OP_VMIN     = 8'h05;
    localparam logic [7:0] OP_VRELU    = 8'h10;
    localparam logic [7:0] OP_VLOAD    = 8'h20;
    localparam logic [7:0] OP_VSTORE   = 8'h21;
    localparam logic [7:0] OP_VZERO    = 8'h34;
    localparam logic [7:0] OP_VSETMASK = 8'h40;

    localparam int F_CLASS_LSB = 120;
    localparam int F_SUBOP_LSB = 112;
    localparam int F_VD_LSB    = 107;
    localparam int F_VS1_LSB   = 102;
    localparam int F_VS2_LSB   = 97;
    localparam int F_ADDR_LSB  = 77;
    localparam int F_ADDR_W    = 20;
    localparam int F_SAT_BIT   = 76;
    localparam int F_SHIFT_LSB = 72;
    localparam int F_MASK_TOP  = 71;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MEM,
        ST_DONE
    } state_t;

    function automatic logic known_subop(input logic [7:0] op);
        case (op)
            OP_VADD, OP_VSUB, OP_VMUL, OP_VMAX, OP_VMIN, OP_VRELU,
            OP_VLOAD, OP_VSTORE, OP_VZERO, OP_VSETMASK: known_subop = 1'b1;
            default:                                    known_subop = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vpu_lane.sv
// One lane of the vector ALU: signed add/sub/mul with optional clamping,
// max/min/relu and zero. Purely combinational.
module vpu_lane
    import vpu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [7:0]            op,
    input  logic                  sat,
    input  logic [3:0]            shift,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    localparam int WW = 2 * DATA_WIDTH;
    localparam logic signed [WW-1:0] MAX_W = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [WW-1:0] MIN_W = ~MAX_W;

    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
    logic signed [WW-1:0]         wide;

    assign sa = a;
    assign sb = b;

    // Intermediates are kept at double width so the clamp sees the true value.
    function automatic logic [DATA_WIDTH-1:0] fit(input logic signed [WW-1:0] v, input logic s);
        if (s && (v > MAX_W))      fit = MAX_W[DATA_WIDTH-1:0];
        else if (s && (v < MIN_W)) fit = MIN_W[DATA_WIDTH-1:0];
        else                       fit = v[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        y    = '0;
        wide = '0;
        case (op)
            OP_VADD: begin
                wide = $signed(WW'(sa)) + $signed(WW'(sb));
                y    = fit(wide, sat);
            end
            OP_VSUB: begin
                wide = $signed(WW'(sa)) - $signed(WW'(sb));
                y    = fit(wide, sat);
            end
            OP_VMUL: begin
                wide = ($signed(WW'(sa)) * $signed(WW'(sb))) >>> shift;
                y    = fit(wide, sat);
            end
            OP_VMAX:  y = (sa > sb) ? a : b;
            OP_VMIN:  y = (sa < sb) ? a : b;
            OP_VRELU: y = sa[DATA_WIDTH-1] ? '0 : a;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/vector_unit_masked.sv
// Lane-masked vector unit: command latch, sequencing FSM, vector register
// file, write mask and SRAM request handling around LANES vpu_lane ALUs.
//
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   EXEC  | ALU / VZERO / VSETMASK / rejected command, commits at next edge
//   MEM   | SRAM load or store outstanding until sram_ready
//   DONE  | cmd_done pulse (cmd_err if rejected)
module vector_unit_masked
    import vpu_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int DATA_WIDTH = 16,
    parameter int VREGS      = 32,
    parameter int SRAM_AW    = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [127:0]                cmd,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    output logic                        cmd_done,
    output logic                        cmd_err,
    output logic [SRAM_AW-1:0]          sram_addr,
    output logic [LANES*DATA_WIDTH-1:0] sram_wdata,
    input  logic [LANES*DATA_WIDTH-1:0] sram_rdata,
    output logic                        sram_we,
    output logic                        sram_re,
    input  logic                        sram_ready
);

    localparam int VW = LANES * DATA_WIDTH;
    localparam int DW = DATA_WIDTH;

    state_t             state_q, state_d;
    logic [7:0]         op_q, op_d;
    logic [4:0]         vd_q, vd_d;
    logic [4:0]         vs1_q, vs1_d;
    logic [4:0]         vs2_q, vs2_d;
    logic               sat_q, sat_d;
    logic [3:0]         shift_q, shift_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [LANES-1:0]   mimm_q, mimm_d;
    logic [LANES-1:0]   mask_q, mask_d;
    logic               err_q, err_d;
    logic [VW-1:0]      wdata_q, wdata_d;

    logic [VW-1:0]      vrf [VREGS];
    logic               vrf_we;
    logic [VW-1:0]      vrf_wdata;
    logic [VW-1:0]      src_a, src_b, old_vd, alu_y;

    logic [7:0]         c_class, c_op;
    logic [4:0]         c_vd, c_vs1, c_vs2;
    logic               c_bad;
    logic               unused_cmd_bits;

    assign c_class = cmd[F_CLASS_LSB +: 8];
    assign c_op    = cmd[F_SUBOP_LSB +: 8];
    assign c_vd    = cmd[F_VD_LSB +: 5];
    assign c_vs1   = cmd[F_VS1_LSB +: 5];
    assign c_vs2   = cmd[F_VS2_LSB +: 5];
    assign c_bad   = (c_class != CLASS_VEC) || !known_subop(c_op) ||
                     (int'(c_vd) >= VREGS) || (int'(c_vs1) >= VREGS) || (int'(c_vs2) >= VREGS);
    assign unused_cmd_bits = ^cmd[F_MASK_TOP:LANES];

    assign src_a  = vrf[vs1_q];
    assign src_b  = vrf[vs2_q];
    assign old_vd = vrf[vd_q];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        vpu_lane #(.DATA_WIDTH(DW)) u_lane (
            .op    (op_q),
            .sat   (sat_q),
            .shift (shift_q),
            .a     (src_a[l*DW +: DW]),
            .b     (src_b[l*DW +: DW]),
            .y     (alu_y[l*DW +: DW])
        );
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        vd_d      = vd_q;
        vs1_d     = vs1_q;
        vs2_d     = vs2_q;
        sat_d     = sat_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        mimm_d    = mimm_q;
        mask_d    = mask_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        vrf_we    = 1'b0;
        vrf_wdata = old_vd;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = c_op;
                    vd_d    = c_vd;
                    vs1_d   = c_vs1;
                    vs2_d   = c_vs2;
                    sat_d   = cmd[F_SAT_BIT];
                    shift_d = cmd[F_SHIFT_LSB +: 4];
                    addr_d  = SRAM_AW'(cmd[F_ADDR_LSB +: F_ADDR_W]);
                    mimm_d  = cmd[LANES-1:0];
                    err_d   = c_bad;
                    if (!c_bad && (c_op == OP_VLOAD || c_op == OP_VSTORE)) state_d = ST_MEM;
                    else                                                   state_d = ST_EXEC;
                    // Store data is snapshotted here so it stays stable while the request waits.
                    if (!c_bad && c_op == OP_VSTORE) wdata_d = vrf[c_vs1];
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                if (!err_q) begin
                    if (op_q == OP_VSETMASK) begin
                        mask_d = mimm_q;
                    end else begin
                        vrf_we = 1'b1;
                        for (int l = 0; l < LANES; l++)
                            if (mask_q[l]) vrf_wdata[l*DW +: DW] = alu_y[l*DW +: DW];
                    end
                end
            end
            ST_MEM: begin
                if (sram_ready) begin
                    state_d = ST_DONE;
                    if (op_q == OP_VLOAD) begin
                        vrf_we = 1'b1;
                        for (int l = 0; l < LANES; l++)
                            if (mask_q[l]) vrf_wdata[l*DW +: DW] = sram_rdata[l*DW +: DW];
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            vd_q    <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            sat_q   <= 1'b0;
            shift_q <= '0;
            addr_q  <= '0;
            mimm_q  <= '0;
            mask_q  <= '1;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            vd_q    <= vd_d;
            vs1_q   <= vs1_d;
            vs2_q   <= vs2_d;
            sat_q   <= sat_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            mimm_q  <= mimm_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
        end
    end

    // Register file has no reset; a reset edge must still suppress the write.
    always_ff @(posedge clk) begin
        if (vrf_we && !rst) vrf[vd_q] <= vrf_wdata;
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign cmd_done   = (state_q == ST_DONE);
    assign cmd_err    = cmd_done && err_q;
    assign sram_re    = (state_q == ST_MEM) && (op_q == OP_VLOAD);
    assign sram_we    = (state_q == ST_MEM) && (op_q == OP_VSTORE);
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

endmodule

// File: doc/vector_unit_masked.md
# vector_unit_masked

Parametrised, lane-masked vector unit: a successor to the fixed 8-lane vector unit. Accepts one 128-bit vector command at a time from the instruction sequencer, executes it across LANES lanes against a VREGS-entry vector register file (`vrf`) or the local SRAM port, then pulses done. Adds per-lane write masking, optional signed saturation, a shifted fixed-point multiply and error reporting.

## Interface
- LANES, 8, number of lanes
- DATA_WIDTH, 16, signed element width
- VREGS, 32, vector registers (≤32; command fields are 5 bits)
- SRAM_AW, 20, SRAM word-address width
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd  in  128  command word
- cmd_valid  in  1  command present
- cmd_ready  out  1  unit idle, command accepted on clk edge when cmd_valid & cmd_ready
- cmd_done  out  1  one-cycle completion pulse
- cmd_err  out  1  valid with cmd_done; command rejected
- sram_addr  out  SRAM_AW  word address
- sram_wdata  out  LANES*DATA_WIDTH  store data, lane 0 in LSBs
- sram_rdata  in  LANES*DATA_WIDTH  load data, valid when sram_ready
- sram_we / sram_re  out  1  write / read request, held until sram_ready
- sram_ready  in  1  completes current request at that edge

## Operation
- Fields: [127:120] class (must be 0x02), [119:112] subop, [111:107] vd, [106:102] vs1, [101:97] vs2, [96:77] addr, [76] sat, [75:72] mul shift, [LANES-1:0] mask immediate (VSETMASK only).
- Subops: 0x01 VADD, 0x02 VSUB, 0x03 VMUL, 0x04 VMAX, 0x05 VMIN, 0x10 VRELU (vs1), 0x20 VLOAD, 0x21 VSTORE (vs1), 0x34 VZERO, 0x40 VSETMASK.
- Wrong class, unknown subop, or any register index ≥ VREGS: no state change, cmd_done=1 with cmd_err=1.
- Mask register, LANES bits, reset all ones. ALU ops, VZERO, VLOAD write only lanes with mask=1; masked-off lanes of vd keep old value. VSTORE ignores mask (writes all lanes). VSETMASK writes mask, touches no vrf.
- Arithmetic signed two's complement. ADD/SUB: sat=0 wraps to DATA_WIDTH; sat=1 clamps to [−2^(DW−1), 2^(DW−1)−1]. VMUL: full 2*DW product, arithmetic right shift by mul shift, then wrap or clamp per sat. VMAX/VMIN/VRELU signed; RELU = max(x,0).
- vd may equal vs1/vs2; sources read before write.
- `vrf` not reset (contents undefined after rst); bench may preload `vrf` hierarchically.
- States: IDLE → EXEC (ALU/ZERO/SETMASK/error) → DONE → IDLE; IDLE → MEM (LOAD/STORE) → DONE → IDLE.

## Timing
- Reset values: cmd_ready=1 (state IDLE), cmd_done=0, cmd_err=0, sram_we=0, sram_re=0, sram_addr=0, sram_wdata=0, mask all ones.
- cmd_ready = (state==IDLE), combinational from state only.
- Accept at edge k → EXEC; write vd at edge k+1 → DONE; cmd_done high in cycle k+1..k+2; IDLE at k+2; next accept earliest edge k+3 if cmd_valid held.
- cmd_valid held through/after acceptance while in non-IDLE states is ignored; command is latched at accept.
- MEM: sram_re or sram_we asserted from cycle after accept, address/wdata stable, until edge with sram_ready=1; VLOAD captures sram_rdata at that edge; then DONE. sram_ready=1 constant → same latency as ALU ops.
- rst mid-command: at that edge → IDLE, no vrf/mask write, sram_re/we low next cycle, no cmd_done.

## Structure
- Package `vpu_pkg`: class code, subop constants, field bit positions, state enum.
- Sub-module `vpu_lane`: one lane's ALU (op, sat, shift, combinational), generate-instantiated LANES times; top holds FSM, vrf, mask, SRAM sequencing.

## Test plan
- Reset, vrf[0]={8..1}, VZERO vd=20 → cmd_done one cycle at k+1, cmd_err=0, vrf[20]=0.
- vrf[1]=all 0x7FF0, vrf[2]=all 0x0020, VADD vd=3 sat=0 → lanes 0x8010; sat=1 → lanes 0x7FFF.
- VSETMASK 0x0F, then VSUB vd=4 (vrf[4] preset 0xAAAA) → lanes 0–3 result, lanes 4–7 stay 0xAAAA.
- VMUL 0x0100×0x0300 shift=8 → 0x0300 each lane; VRELU on {−5,5,...} → {0,5,...}.
- VLOAD addr=0x12345 with sram_ready low 3 cycles → sram_re held, sram_addr=0x12345, vd written only on ready edge; VSTORE drives sram_wdata=vrf[vs1].
- subop 0xFF → cmd_done+cmd_err, vrf unchanged; assert rst during MEM → no done, IDLE, sram_re=0.
